// File: rtl/peri_bridge_axil_if.sv
// peri_bridge_axil_if
// AXI4-Lite-style peripheral bus bundle (AW, W, B, AR, R channels).
// The bridge connects through the master modport; the peripheral (or a
// bus model) connects through the slave modport.
//   aw_addr/aw_valid/aw_ready          : write address channel
//   w_data/w_strb/w_valid/w_ready      : write data channel
//   b_resp/b_valid/b_ready             : write response channel
//   ar_addr/ar_valid/ar_ready          : read address channel
//   r_data/r_resp/r_valid/r_ready      : read data channel
interface peri_bridge_axil_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic                    aw_valid;
    logic                    aw_ready;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_valid;
    logic                    w_ready;
    logic [1:0]              b_resp;
    logic                    b_valid;
    logic                    b_ready;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic                    ar_valid;
    logic                    ar_ready;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_valid;
    logic                    r_ready;

    modport master (
        output aw_addr, aw_valid, input aw_ready,
        output w_data, w_strb, w_valid, input w_ready,
        input  b_resp, b_valid, output b_ready,
        output ar_addr, ar_valid, input ar_ready,
        input  r_data, r_resp, r_valid, output r_ready
    );

    modport slave (
        input  aw_addr, aw_valid, output aw_ready,
        input  w_data, w_strb, w_valid, output w_ready,
        output b_resp, b_valid, input b_ready,
        input  ar_addr, ar_valid, output ar_ready,
        output r_data, r_resp, r_valid, input r_ready
    );
endinterface

// File: rtl/peri_bridge_axil.sv
// peri_bridge_axil
// Single-outstanding bridge from the data-cache uncached/peripheral request
// port to an AXI4-Lite-style peripheral bus. One request at a time; the
// result is held on done_o until the cache acknowledges it. Slave error
// responses and bus timeouts are reported on error_o.
// Ports:
//   clk, rst_n           : clock (rising edge), async active-low reset
//   start_i, write_i     : request strobe / direction (1 = write), IDLE only
//   address_i, data_in_i, wstrb_i : request address, write data, strobes
//   data_out_o           : registered read data
//   done_o, error_o      : completion and its error flag
//   cache_ready_dat_i    : cache consumed the result
//   peri                 : peripheral bus (master side)
//
// state    | meaning
// ---------+-------------------------------------------------
// S_IDLE   | waiting for start_i
// S_WR_REQ | AW and W valid, each until its own handshake
// S_WR_RSP | b_ready high, waiting for write response
// S_RD_REQ | AR valid, waiting for ar_ready
// S_RD_RSP | r_ready high, waiting for read data
// S_CPLT   | done_o high until cache_ready_dat_i
module peri_bridge_axil #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic                    write_i,
    input  logic [ADDR_WIDTH-1:0]   address_i,
    input  logic [DATA_WIDTH-1:0]   data_in_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    output logic [DATA_WIDTH-1:0]   data_out_o,
    output logic                    done_o,
    output logic                    error_o,
    input  logic                    cache_ready_dat_i,
    peri_bridge_axil_if.master      peri
);
    typedef enum logic [2:0] {
        S_IDLE, S_WR_REQ, S_WR_RSP, S_RD_REQ, S_RD_RSP, S_CPLT
    } state_t;

    localparam bit                   TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    aw_valid_q, aw_valid_d;
    logic                    w_valid_q, w_valid_d;
    logic                    ar_valid_q, ar_valid_d;
    logic                    b_ready_q, b_ready_d;
    logic                    r_ready_q, r_ready_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   w_data_q, w_data_d;
    logic [DATA_WIDTH/8-1:0] w_strb_q, w_strb_d;

    logic aw_hs, w_hs, ar_hs, b_hs, r_hs, both_done, busy, expire;
    logic unused_resp_lsb;

    assign aw_hs = aw_valid_q & peri.aw_ready;
    assign w_hs  = w_valid_q  & peri.w_ready;
    assign ar_hs = ar_valid_q & peri.ar_ready;
    assign b_hs  = b_ready_q  & peri.b_valid;
    assign r_hs  = r_ready_q  & peri.r_valid;
    // AW and W each either handshook earlier (valid already low) or now.
    assign both_done = (~aw_valid_q | peri.aw_ready) & (~w_valid_q | peri.w_ready);
    assign busy = (state_q == S_WR_REQ) || (state_q == S_WR_RSP) ||
                  (state_q == S_RD_REQ) || (state_q == S_RD_RSP);
    assign expire = TMO_EN && busy && (cnt_q == CNT_LAST);
    assign unused_resp_lsb = peri.b_resp[0] ^ peri.r_resp[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            b_ready_q  <= 1'b0;
            r_ready_q  <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            data_out_q <= '0;
            addr_q     <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            aw_valid_q <= aw_valid_d;
            w_valid_q  <= w_valid_d;
            ar_valid_q <= ar_valid_d;
            b_ready_q  <= b_ready_d;
            r_ready_q  <= r_ready_d;
            done_q     <= done_d;
            error_q    <= error_d;
            data_out_q <= data_out_d;
            addr_q     <= addr_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
        end
    end

    // Only the B or R handshake completes a transaction; an AW/W/AR
    // handshake landing on the expiry cycle still aborts, since the
    // response phase would have no budget left.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start_i) state_d = write_i ? S_WR_REQ : S_RD_REQ;
            S_WR_REQ: if (expire) state_d = S_CPLT;
                      else if (both_done) state_d = S_WR_RSP;
            S_WR_RSP: if (b_hs || expire) state_d = S_CPLT;
            S_RD_REQ: if (expire) state_d = S_CPLT;
                      else if (ar_hs) state_d = S_RD_RSP;
            S_RD_RSP: if (r_hs || expire) state_d = S_CPLT;
            S_CPLT:   if (cache_ready_dat_i) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        aw_valid_d = aw_valid_q;
        w_valid_d  = w_valid_q;
        ar_valid_d = ar_valid_q;
        b_ready_d  = b_ready_q;
        r_ready_d  = r_ready_q;
        done_d     = done_q;
        error_d    = error_q;
        data_out_d = data_out_q;
        addr_d     = addr_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        if (busy) cnt_d = cnt_q + CNT_WIDTH'(1);
        unique case (state_q)
            S_IDLE: if (start_i) begin
                addr_d   = address_i;
                w_data_d = data_in_i;
                w_strb_d = wstrb_i;
                cnt_d    = '0;
                if (write_i) begin
                    aw_valid_d = 1'b1;
                    w_valid_d  = 1'b1;
                end else begin
                    ar_valid_d = 1'b1;
                end
            end
            S_WR_REQ: begin
                if (aw_hs) aw_valid_d = 1'b0;
                if (w_hs)  w_valid_d  = 1'b0;
                if (expire) begin
                    aw_valid_d = 1'b0;
                    w_valid_d  = 1'b0;
                    error_d    = 1'b1;
                    done_d     = 1'b1;
                end else if (both_done) begin
                    b_ready_d = 1'b1;
                end
            end
            S_WR_RSP: if (b_hs || expire) begin
                b_ready_d = 1'b0;
                done_d    = 1'b1;
                error_d   = b_hs ? peri.b_resp[1] : 1'b1;
            end
            S_RD_REQ: begin
                if (expire) begin
                    ar_valid_d = 1'b0;
                    error_d    = 1'b1;
                    done_d     = 1'b1;
                    data_out_d = '1;
                end else if (ar_hs) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                end
            end
            S_RD_RSP: if (r_hs || expire) begin
                r_ready_d  = 1'b0;
                done_d     = 1'b1;
                error_d    = r_hs ? peri.r_resp[1] : 1'b1;
                data_out_d = r_hs ? peri.r_data : '1;
            end
            S_CPLT: if (cache_ready_dat_i) begin
                done_d  = 1'b0;
                error_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign data_out_o    = data_out_q;
    assign done_o        = done_q;
    assign error_o       = error_q;
    assign peri.aw_addr  = addr_q;
    assign peri.aw_valid = aw_valid_q;
    assign peri.w_data   = w_data_q;
    assign peri.w_strb   = w_strb_q;
    assign peri.w_valid  = w_valid_q;
    assign peri.b_ready  = b_ready_q;
    assign peri.ar_addr  = addr_q;
    assign peri.ar_valid = ar_valid_q;
    assign peri.r_ready  = r_ready_q;
endmodule

// File: tb/tb_peri_bridge_axil.sv
module tb_peri_bridge_axil;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, write = 1'b0, ack = 1'b0;
    logic [31:0] address = '0, data_in = '0;
    logic [3:0]  wstrb = '0;
    logic [31:0] data_out;
    logic        done, error;
    int          cyc = 0;
    int          total = 0, bad = 0;

    peri_bridge_axil_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    peri_bridge_axil #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO), .CNT_WIDTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .write_i(write),
        .address_i(address), .data_in_i(data_in), .wstrb_i(wstrb),
        .data_out_o(data_out), .done_o(done), .error_o(error),
        .cache_ready_dat_i(ack), .peri(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          wr;
        logic [31:0] addr, data;
        logic [3:0]  strb;
        logic        err;
        logic [31:0] rdata;
        int          done_cyc, a_cnt, w_cnt, rsp_cyc;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic int imax(input int a, input int b); return (a > b) ? a : b; endfunction
    function automatic int imin(input int a, input int b); return (a < b) ? a : b; endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic slave_idle();
        bus.aw_ready = 0; bus.w_ready = 0; bus.ar_ready = 0;
        bus.b_valid = 0; bus.r_valid = 0;
    endtask

    // d_a: address-ready delay, d_w: write-data-ready delay, rise: first
    // cycle of the response VALID (it then holds until accepted).
    task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int d_a, input int d_w, input int rise,
                          input logic [1:0] resp, input logic [31:0] rdata,
                          input int ack_wait, input bit hold, input bit nosync);
        exp_t e;
        int   n0, ha, hw, hend;
        bit   to;
        if (!nosync) sync();
        n0 = cyc;
        start = 1; write = wr; address = addr; data_in = data; wstrb = strb;
        ha   = d_a + 1;
        hw   = wr ? d_w + 1 : 0;
        hend = imax(wr ? imax(ha, hw) + 1 : ha + 1, rise);
        to   = hend > TMO;
        e.wr = wr; e.addr = addr; e.data = data; e.strb = strb;
        e.err      = to ? 1'b1 : resp[1];
        e.rdata    = to ? 32'hFFFF_FFFF : rdata;
        e.done_cyc = n0 + (to ? TMO : hend) + 1;
        e.a_cnt    = imin(ha, TMO);
        e.w_cnt    = wr ? imin(hw, TMO) : 0;
        e.rsp_cyc  = n0 + hend;
        exp_q.push_back(e);
        bus.b_resp = resp; bus.r_resp = resp; bus.r_data = rdata;
        for (int c = 1; c <= hend; c++) begin
            sync();
            if (!hold) start = 0;
            bus.aw_ready = wr && (c == ha);
            bus.w_ready  = wr && (c == hw);
            bus.ar_ready = !wr && (c == ha);
            bus.b_valid  = wr && (c >= rise);
            bus.r_valid  = !wr && (c >= rise);
        end
        sync();
        slave_idle();
        for (int i = 0; i < 40 && !done; i++) sync();
        check("done_seen", done, 1'b1);
        repeat (ack_wait) sync();
        ack = 1;
        sync();
        ack = 0;
    endtask

    // Scoreboard monitor: checks channel contents at each handshake and the
    // completed result whenever DONE rises.
    int aw_n = 0, w_n = 0, ar_n = 0;
    bit done_prev = 0, ack_prev = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            aw_n = 0; w_n = 0; ar_n = 0; done_prev = 0; ack_prev = 0;
        end else begin
            aw_n += int'(bus.aw_valid);
            w_n  += int'(bus.w_valid);
            ar_n += int'(bus.ar_valid);
            if (bus.aw_valid && bus.aw_ready) begin
                if (exp_q.size() == 0) check("aw_unexpected", bus.aw_valid, 1'b0);
                else check("aw_addr", bus.aw_addr, exp_q[0].addr);
            end
            if (bus.w_valid && bus.w_ready) begin
                if (exp_q.size() == 0) check("w_unexpected", bus.w_valid, 1'b0);
                else begin
                    check("w_data", bus.w_data, exp_q[0].data);
                    check("w_strb", {28'h0, bus.w_strb}, {28'h0, exp_q[0].strb});
                end
            end
            if (bus.ar_valid && bus.ar_ready) begin
                if (exp_q.size() == 0) check("ar_unexpected", bus.ar_valid, 1'b0);
                else check("ar_addr", bus.ar_addr, exp_q[0].addr);
            end
            if (bus.b_valid && bus.b_ready && exp_q.size() != 0)
                check("b_cycle", cyc, exp_q[0].rsp_cyc);
            if (bus.r_valid && bus.r_ready && exp_q.size() != 0)
                check("r_cycle", cyc, exp_q[0].rsp_cyc);
            if (done_prev) begin
                if (ack_prev) check("done_fall", {30'h0, done, error}, 32'h0);
                else check("done_hold", done, 1'b1);
            end
            if (done && !done_prev) begin
                if (exp_q.size() == 0) check("done_unexpected", done, 1'b0);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("error", error, e.err);
                    check("done_cycle", cyc, e.done_cyc);
                    check(e.wr ? "aw_valid_cycles" : "ar_valid_cycles", e.wr ? aw_n : ar_n, e.a_cnt);
                    check("w_valid_cycles", w_n, e.w_cnt);
                    check("other_addr_valid_cycles", e.wr ? ar_n : aw_n, 0);
                    if (!e.wr) check("data_out", data_out, e.rdata);
                end
                aw_n = 0; w_n = 0; ar_n = 0;
            end
            done_prev = done;
            ack_prev  = ack;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data_out"}, data_out, 32'h0);
        check({tag, "_ctrl"}, {25'h0, bus.aw_valid, bus.w_valid, bus.b_ready, bus.ar_valid,
                               bus.r_ready, done, error}, 32'h0);
        check({tag, "_chan"}, bus.aw_addr | bus.ar_addr | bus.w_data | {28'h0, bus.w_strb}, 32'h0);
    endtask

    initial begin
        logic [31:0] a, d, rd;
        logic [3:0]  s;
        logic [1:0]  rsp;
        bit          wr;
        slave_idle();
        bus.b_resp = 0; bus.r_resp = 0; bus.r_data = 0;
        repeat (3) sync();
        check_reset_outputs("reset");
        rst_n = 1;
        sync();

        // zero-wait write, OKAY
        do_txn(1, 32'h4000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 2, 2'b00, 0, 3, 0, 0);
        // AW ready delayed 3 cycles, W immediate, B offered early
        do_txn(1, 32'h4000_0014, 32'hCAFE_F00D, 4'h3, 3, 0, 2, 2'b00, 0, 1, 0, 0);
        // read with SLVERR after 5 wait cycles
        do_txn(0, 32'h4000_0020, 0, 0, 0, 0, 7, 2'b10, 32'h1234_5678, 0, 0, 0);
        // read with AR ready stuck low -> timeout
        do_txn(0, 32'h4000_0030, 0, 0, 40, 0, 45, 2'b00, 32'h5555_AAAA, 2, 0, 0);

        // reset while waiting in WR_RSP
        sync();
        start = 1; write = 1; address = 32'h4000_0100; data_in = 32'h0BAD_F00D; wstrb = 4'h3;
        exp_q.push_back('{1, 32'h4000_0100, 32'h0BAD_F00D, 4'h3, 0, 0, 0, 0, 0, 0});
        sync(); start = 0; bus.aw_ready = 1; bus.w_ready = 1;
        sync(); slave_idle();
        sync();
        check("wr_rsp_b_ready", bus.b_ready, 1'b1);
        rst_n = 0;
        #1;
        check_reset_outputs("midreset");
        sync(); rst_n = 1;
        do_txn(0, 32'h4000_0040, 0, 0, 1, 0, 3, 2'b00, 32'h0F0F_1234, 1, 0, 0);

        // START held high through CPLT; second request must follow IDLE once
        do_txn(1, 32'h4000_0050, 32'h1111_2222, 4'hC, 0, 0, 2, 2'b01, 0, 4, 1, 0);
        do_txn(1, 32'h4000_0054, 32'h3333_4444, 4'h1, 0, 0, 2, 2'b00, 0, 0, 0, 1);

        for (int t = 0; t < 30; t++) begin
            wr  = 1'($urandom_range(0, 1));
            a   = $urandom() & 32'hFFFF_FFFC;
            d   = $urandom();
            rd  = $urandom();
            s   = 4'($urandom_range(0, 15));
            rsp = 2'($urandom_range(0, 3));
            do_txn(wr, a, d, s, $urandom_range(0, 4), $urandom_range(0, 4),
                   $urandom_range(1, 10), rsp, rd, $urandom_range(0, 3), 0, 0);
        end

        repeat (5) sync();
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
